// File: rtl/lfsr_rng_sched.sv
// rtl/lfsr_rng_sched.sv - round-robin scheduler sharing one 26-bit Fibonacci LFSR among NREQ requesters
//
// Each granted request steps the LFSR STEPS times, then delivers the resulting
// 26-bit value with a one-cycle one-hot grant. Seed loading is sequenced
// through the same FSM so it never races a service in flight.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active-high
//   seed_load  load seed request, honoured only while idle (dropped when busy)
//   seed       seed value [1:26]; zero seed loads 26'h0000001 instead
//   req        per-requester level request, held until granted
//   gnt        one-hot grant pulse, coincident with rnd_valid
//   rnd_valid  one-cycle pulse, rnd_data valid
//   rnd_data   delivered sample [1:26], holds between pulses
//   busy       high whenever the FSM is not idle
//   sample_cnt (only with LFSR_RNG_SCHED_CNT_EN) wrapping count of delivered samples,
//              cleared by reset and by seed loading
//
// Optional feature macro: LFSR_RNG_SCHED_CNT_EN

module lfsr_rng_sched #(
    parameter int NREQ  = 4,
    parameter int STEPS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            seed_load,
    input  logic [1:26]     seed,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            rnd_valid,
    output logic [1:26]     rnd_data,
`ifdef LFSR_RNG_SCHED_CNT_EN
    output logic [15:0]     sample_cnt,
`endif
    output logic            busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0]      STEPS_L = 4'(STEPS);
    localparam logic [NREQ-1:0] GNT_ONE = NREQ'(1);
    localparam logic [1:26]     LFSR_INIT = 26'h0000001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEED    = 2'd1,
        ADVANCE = 2'd2,
        DELIVER = 2'd3
    } state_t;

    state_t        state;
    logic [1:26]   lfsr;
    logic [1:26]   lfsr_next;
    logic [1:26]   seed_q;
    logic [3:0]    step_cnt;
    logic [PW-1:0] ptr;
    logic [PW-1:0] winner;
    logic [PW-1:0] pick;
    logic          found;
    int            idx;

    // One LFSR shift; an all-zero state would lock up, so it restarts from 1.
    always_comb begin
        lfsr_next = LFSR_INIT;
        if (lfsr != '0) begin
            lfsr_next = {lfsr[26] ^ lfsr[8] ^ lfsr[7] ^ lfsr[1], lfsr[1:25]};
        end
    end

    // Round-robin search starting at ptr, wrapping at NREQ-1.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lfsr      <= LFSR_INIT;
            seed_q    <= '0;
            step_cnt  <= '0;
            ptr       <= '0;
            winner    <= '0;
            gnt       <= '0;
            rnd_valid <= 1'b0;
            rnd_data  <= '0;
            busy      <= 1'b0;
`ifdef LFSR_RNG_SCHED_CNT_EN
            sample_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // Seeding wins over a same-cycle request; the request stays
                    // pending and is picked up on the return to IDLE.
                    if (seed_load) begin
                        seed_q <= seed;
                        state  <= SEED;
                        busy   <= 1'b1;
`ifdef LFSR_RNG_SCHED_CNT_EN
                        sample_cnt <= '0;
`endif
                    end else if (found) begin
                        winner   <= pick;
                        step_cnt <= STEPS_L;
                        state    <= ADVANCE;
                        busy     <= 1'b1;
                    end
                end
                SEED: begin
                    lfsr  <= (|seed_q) ? seed_q : LFSR_INIT;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                ADVANCE: begin
                    lfsr     <= lfsr_next;
                    step_cnt <= step_cnt - 4'd1;
                    if (step_cnt == 4'd1) begin
                        // Deliver the value produced by this final step.
                        state     <= DELIVER;
                        gnt       <= GNT_ONE << winner;
                        rnd_valid <= 1'b1;
                        rnd_data  <= lfsr_next;
`ifdef LFSR_RNG_SCHED_CNT_EN
                        sample_cnt <= sample_cnt + 16'd1;
`endif
                    end
                end
                DELIVER: begin
                    gnt       <= '0;
                    rnd_valid <= 1'b0;
                    ptr       <= (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
                    state     <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_rng_sched.sv
// tb/tb_lfsr_rng_sched.sv - scoreboard testbench for lfsr_rng_sched

module tb_lfsr_rng_sched;

    localparam int NREQ  = 4;
    localparam int STEPS = 4;
    localparam int LAT   = STEPS + 1;
    localparam int PER   = STEPS + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_load = 1'b0;
    logic [25:0] seed = '0;
    logic [3:0]  req = '0;
    logic [3:0]  gnt;
    logic        rnd_valid;
    logic [25:0] rnd_data;
    logic        busy;
`ifdef LFSR_RNG_SCHED_CNT_EN
    logic [15:0] sample_cnt;
`endif

    lfsr_rng_sched #(.NREQ(NREQ), .STEPS(STEPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed      (seed),
        .req       (req),
        .gnt       (gnt),
        .rnd_valid (rnd_valid),
        .rnd_data  (rnd_data),
`ifdef LFSR_RNG_SCHED_CNT_EN
        .sample_cnt(sample_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  gnt;
        logic [25:0] data;
        int          at;
    } exp_t;

    exp_t expq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_val);
        checks++;
        if (act !== req_val) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req_val, cyc);
        end
    endtask

    task automatic expect_grant(input logic [3:0] g, input logic [25:0] d, input int at);
        exp_t e;
        e.gnt  = g;
        e.data = d;
        e.at   = at;
        expq.push_back(e);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Monitor: every delivered sample is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rnd_valid === 1'b1) begin
                if (expq.size() == 0) begin
                    check("unexpected_valid", 32'(rnd_valid), 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("gnt", 32'(gnt), 32'(e.gnt));
                    check("rnd_data", 32'(rnd_data), 32'(e.data));
                    check("grant_cycle", 32'(cyc), 32'(e.at));
                    check("busy_at_grant", 32'(busy), 32'd1);
                end
            end else if (gnt !== 4'b0000) begin
                check("gnt_without_valid", 32'(gnt), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int c;
        repeat (2) @(negedge clk);
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_valid", 32'(rnd_valid), 32'd0);
        check("reset_data", 32'(rnd_data), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Default seed, requester 0.
        c = cyc;
        req = 4'b0001;
        expect_grant(4'b0001, 26'h3C00000, c + LAT);
        wait_until(c + 2);
        check("busy_in_advance", 32'(busy), 32'd1);
        wait_until(c + LAT);
        req = 4'b0000;
        @(negedge clk);
        check("post_gnt", 32'(gnt), 32'd0);
        check("post_valid", 32'(rnd_valid), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("data_hold", 32'(rnd_data), 32'h3C00000);

        // Zero seed falls back to 1, then requester 1.
        seed = 26'h0;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        check("busy_in_seed", 32'(busy), 32'd1);
        @(negedge clk);
        c = cyc;
        req = 4'b0010;
        expect_grant(4'b0010, 26'h3C00000, c + LAT);
        wait_until(c + LAT);
        req = 4'b0000;
        @(negedge clk);

        // Fresh reset, all requesters held: rotation and consecutive windows.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        c = cyc;
        req = 4'b1111;
        expect_grant(4'b0001, 26'h3C00000, c + LAT);
        expect_grant(4'b0010, 26'h1FC0000, c + LAT + PER);
        expect_grant(4'b0100, 26'h01FC000, c + LAT + 2 * PER);
        expect_grant(4'b1000, 26'h301FC00, c + LAT + 3 * PER);
        expect_grant(4'b0001, 26'h3F01FC0, c + LAT + 4 * PER);
        wait_until(c + LAT + 4 * PER);
        req = 4'b0000;
        @(negedge clk);

        // Seed and request together: seeding first, grant after SEED and re-arbitration.
        c = cyc;
        seed = 26'h2000000;
        seed_load = 1'b1;
        req = 4'b0100;
        expect_grant(4'b0100, 26'h3E00000, c + 2 + LAT);
        @(negedge clk);
        seed_load = 1'b0;
        wait_until(c + 2 + LAT);
        req = 4'b0000;
        @(negedge clk);

        // seed_load while busy is dropped.
        c = cyc;
        req = 4'b0001;
        expect_grant(4'b0001, 26'h0FE0000, c + LAT);
        wait_until(c + 2);
        seed = 26'h0;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        wait_until(c + LAT);
        req = 4'b0000;
        @(negedge clk);

        // Asynchronous reset mid-service: outputs clear at once, no grant follows.
        c = cyc;
        req = 4'b0010;
        wait_until(c + 2);
        rst = 1'b1;
        #1;
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_valid", 32'(rnd_valid), 32'd0);
        check("midrst_data", 32'(rnd_data), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // LFSR restarted by reset; then two more windows of the same sequence.
        c = cyc;
        req = 4'b0001;
        expect_grant(4'b0001, 26'h3C00000, c + LAT);
        wait_until(c + LAT);
        req = 4'b0000;
        @(negedge clk);
        c = cyc;
        req = 4'b0001;
        expect_grant(4'b0001, 26'h1FC0000, c + LAT);
        wait_until(c + LAT);
        req = 4'b0000;
        @(negedge clk);
        c = cyc;
        req = 4'b0001;
        expect_grant(4'b0001, 26'h01FC000, c + LAT);
        wait_until(c + LAT);
        req = 4'b0000;
        @(negedge clk);

`ifdef LFSR_RNG_SCHED_CNT_EN
        check("sample_cnt_3", 32'(sample_cnt), 32'd3);
        seed = 26'h0;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        @(negedge clk);
        check("sample_cnt_seed", 32'(sample_cnt), 32'd0);
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
